// File: rtl/dot_product_acc_if.sv
// Job, beat and result signals of the pipelined dot-product accumulator.
// master drives jobs and beats; slave is the accumulator itself.
interface dot_product_acc_if #(
   parameter int unsigned PIXEL_SIZE  = 10,
   parameter int unsigned WEIGHT_SIZE = 19,
   parameter int unsigned VAL_SIZE    = 26,
   parameter int unsigned LANES       = 2,
   parameter int unsigned LEN_W       = 10
);
   logic                            start;
   logic [LEN_W-1:0]                len;
   logic                            in_valid;
   logic                            in_ready;
   logic [LANES*PIXEL_SIZE-1:0]     pixels;
   logic [LANES*WEIGHT_SIZE-1:0]    weights;
   logic                            out_valid;
   logic                            out_ready;
   logic signed [VAL_SIZE-1:0]      value;
   logic                            busy;

   modport master (
      output start, len, in_valid, pixels, weights, out_ready,
      input  in_ready, out_valid, value, busy
   );

   modport slave (
      input  start, len, in_valid, pixels, weights, out_ready,
      output in_ready, out_valid, value, busy
   );
endinterface

// File: rtl/dot_product_acc.sv
// Multi-lane dot-product accumulator: pipelined signed multiplies feed interleaved
// saturating partial-sum banks, reduced to one saturated result per job.
module dot_product_acc #(
   parameter int unsigned PIXEL_SIZE  = 10,
   parameter int unsigned WEIGHT_SIZE = 19,
   parameter int unsigned VAL_SIZE    = 26,
   parameter int unsigned LANES       = 2,
   parameter int unsigned ACC_BANKS   = 3,
   parameter int unsigned MUL_DELAY   = 6,
   parameter int unsigned LEN_W       = 10
) (
   input logic               clk,
   input logic               GlobalReset,
   dot_product_acc_if.slave  bus
);

   localparam int unsigned PROD_W = PIXEL_SIZE + WEIGHT_SIZE + 1;
   localparam int unsigned ACC_W  = ((PROD_W > VAL_SIZE) ? PROD_W : VAL_SIZE) + 1;
   localparam int unsigned NBANK  = LANES * ACC_BANKS;
   localparam int unsigned RED_W  = VAL_SIZE + $clog2(NBANK) + 1;
   localparam int unsigned PTR_W  = (ACC_BANKS > 1) ? $clog2(ACC_BANKS) : 1;
   localparam int unsigned DCNT_W = $clog2(MUL_DELAY + 1);

   localparam logic signed [VAL_SIZE-1:0] VAL_MAX = {1'b0, {(VAL_SIZE-1){1'b1}}};
   localparam logic signed [VAL_SIZE-1:0] VAL_MIN = {1'b1, {(VAL_SIZE-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]    ACC_MAX = {{(ACC_W-VAL_SIZE+1){1'b0}}, {(VAL_SIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]    ACC_MIN = {{(ACC_W-VAL_SIZE+1){1'b1}}, {(VAL_SIZE-1){1'b0}}};
   localparam logic signed [RED_W-1:0]    RED_MAX = {{(RED_W-VAL_SIZE+1){1'b0}}, {(VAL_SIZE-1){1'b1}}};
   localparam logic signed [RED_W-1:0]    RED_MIN = {{(RED_W-VAL_SIZE+1){1'b1}}, {(VAL_SIZE-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_REDUCE,
      S_OUT
   } state_t;

   state_t state_q, state_d;

   logic                       clear_c;
   logic                       zero_c;
   logic                       accept_c;
   logic [LEN_W-1:0]           beat_cnt_q;
   logic [DCNT_W-1:0]          drain_cnt_q;
   logic                       in_ready_q;
   logic                       out_valid_q;
   logic                       busy_q;
   logic signed [VAL_SIZE-1:0] value_q;

   logic signed [PROD_W-1:0]   prod_c [LANES];
   logic signed [PROD_W-1:0]   pipe_q [MUL_DELAY][LANES];
   logic [MUL_DELAY-1:0]       pvld_q;
   logic signed [VAL_SIZE-1:0] bank_q [LANES][ACC_BANKS];
   logic [PTR_W-1:0]           ptr_q;
   logic signed [RED_W-1:0]    red_c;
   logic signed [VAL_SIZE-1:0] red_sat_c;

   function automatic logic signed [VAL_SIZE-1:0] clamp_acc(input logic signed [ACC_W-1:0] x);
      logic signed [VAL_SIZE-1:0] r;
      if (x > ACC_MAX)      r = VAL_MAX;
      else if (x < ACC_MIN) r = VAL_MIN;
      else                  r = x[VAL_SIZE-1:0];
      return r;
   endfunction

   function automatic logic signed [VAL_SIZE-1:0] clamp_red(input logic signed [RED_W-1:0] x);
      logic signed [VAL_SIZE-1:0] r;
      if (x > RED_MAX)      r = VAL_MAX;
      else if (x < RED_MIN) r = VAL_MIN;
      else                  r = x[VAL_SIZE-1:0];
      return r;
   endfunction

   assign accept_c = bus.in_valid & in_ready_q;

   // Pixels are unsigned: zero-extend before the signed multiply.
   always_comb begin
      logic signed [PROD_W-1:0] px;
      logic signed [PROD_W-1:0] wt;
      px = '0;
      wt = '0;
      for (int k = 0; k < LANES; k++) begin
         px        = PROD_W'($signed({1'b0, bus.pixels[k*PIXEL_SIZE +: PIXEL_SIZE]}));
         wt        = PROD_W'($signed(bus.weights[k*WEIGHT_SIZE +: WEIGHT_SIZE]));
         prod_c[k] = px * wt;
      end
   end

   // Full-precision reduction of all banks, clamped once at the end.
   always_comb begin
      red_c = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int b = 0; b < ACC_BANKS; b++) begin
            red_c = red_c + RED_W'(bank_q[k][b]);
         end
      end
      red_sat_c = clamp_red(red_c);
   end

   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      clear_c = 1'b0;
      zero_c  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  state_d = S_RUN;
                  clear_c = 1'b1;
               end else begin
                  state_d = S_OUT;
                  zero_c  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept_c && (beat_cnt_q == LEN_W'(1))) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt_q == '0) state_d = S_REDUCE;
         end
         S_REDUCE: state_d = S_OUT;
         S_OUT: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Job counters, result register and registered handshake outputs.
   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
         value_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (clear_c)       beat_cnt_q <= bus.len;
         else if (accept_c) beat_cnt_q <= beat_cnt_q - LEN_W'(1);

         if (state_q == S_RUN && state_d == S_DRAIN)
            drain_cnt_q <= DCNT_W'(MUL_DELAY);
         else if (state_q == S_DRAIN && drain_cnt_q != '0)
            drain_cnt_q <= drain_cnt_q - DCNT_W'(1);

         if (zero_c)                   value_q <= '0;
         else if (state_q == S_REDUCE) value_q <= red_sat_c;

         in_ready_q  <= (state_d == S_RUN);
         out_valid_q <= (state_d == S_OUT);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   // Multiplier pipeline and bank accumulation; the pointer moves only on delivered products.
   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         pvld_q <= '0;
         ptr_q  <= '0;
         for (int i = 0; i < MUL_DELAY; i++) begin
            for (int k = 0; k < LANES; k++) pipe_q[i][k] <= '0;
         end
         for (int k = 0; k < LANES; k++) begin
            for (int b = 0; b < ACC_BANKS; b++) bank_q[k][b] <= '0;
         end
      end else begin
         pvld_q[0] <= accept_c;
         for (int k = 0; k < LANES; k++) pipe_q[0][k] <= prod_c[k];
         for (int i = 1; i < MUL_DELAY; i++) begin
            pvld_q[i] <= pvld_q[i-1];
            for (int k = 0; k < LANES; k++) pipe_q[i][k] <= pipe_q[i-1][k];
         end

         if (clear_c) begin
            ptr_q <= '0;
            for (int k = 0; k < LANES; k++) begin
               for (int b = 0; b < ACC_BANKS; b++) bank_q[k][b] <= '0;
            end
         end else if (pvld_q[MUL_DELAY-1]) begin
            for (int k = 0; k < LANES; k++) begin
               bank_q[k][ptr_q] <= clamp_acc(ACC_W'(bank_q[k][ptr_q]) +
                                             ACC_W'(pipe_q[MUL_DELAY-1][k]));
            end
            ptr_q <= (ptr_q == PTR_W'(ACC_BANKS - 1)) ? '0 : ptr_q + PTR_W'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.value     = value_q;

   a_ready_only_in_run: assert property (@(posedge clk) disable iff (GlobalReset)
      in_ready_q == (state_q == S_RUN));

endmodule

// File: tb/tb_dot_product_acc.sv
// Randomized scoreboard bench for dot_product_acc: a driver issues jobs and queues
// expected results; an independent monitor pops and checks each presented result.
module tb_dot_product_acc;
   localparam int unsigned P  = 10;
   localparam int unsigned W  = 19;
   localparam int unsigned V  = 26;
   localparam int unsigned L  = 2;
   localparam int unsigned B  = 3;
   localparam int unsigned D  = 6;
   localparam int unsigned LW = 10;

   logic clk = 1'b0;
   logic GlobalReset;
   always #5 clk = ~clk;

   dot_product_acc_if #(.PIXEL_SIZE(P), .WEIGHT_SIZE(W), .VAL_SIZE(V), .LANES(L), .LEN_W(LW)) bus ();

   dot_product_acc #(
      .PIXEL_SIZE(P), .WEIGHT_SIZE(W), .VAL_SIZE(V), .LANES(L),
      .ACC_BANKS(B), .MUL_DELAY(D), .LEN_W(LW)
   ) dut (
      .clk(clk),
      .GlobalReset(GlobalReset),
      .bus(bus)
   );

   typedef struct {
      longint      val;
      int unsigned due;
      int          hold;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   int          done_cnt = 0;
   longint      mbank[L][B];
   int          mptr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic longint clamp(input longint x);
      longint lim;
      lim = longint'(1) << (V - 1);
      if (x > lim - 1) return lim - 1;
      if (x < -lim) return -lim;
      return x;
   endfunction

   // Reference: per-lane banks filled round-robin, each addition clamped to the result range.
   function automatic void model_clear();
      for (int k = 0; k < L; k++)
         for (int b = 0; b < B; b++) mbank[k][b] = 0;
      mptr = 0;
   endfunction

   function automatic void model_beat(input logic [L*P-1:0] px, input logic [L*W-1:0] wt);
      logic signed [W-1:0] ws;
      longint pv;
      for (int k = 0; k < L; k++) begin
         pv = longint'(px[k*P +: P]);
         ws = wt[k*W +: W];
         mbank[k][mptr] = clamp(mbank[k][mptr] + pv * longint'(ws));
      end
      mptr = (mptr + 1) % B;
   endfunction

   function automatic longint model_result();
      longint s;
      s = 0;
      for (int k = 0; k < L; k++)
         for (int b = 0; b < B; b++) s += mbank[k][b];
      return clamp(s);
   endfunction

   task automatic check_reset_state();
      check("rst_in_ready", longint'(bus.in_ready), 0);
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_value", bus.value, 0);
   endtask

   // Monitor: every presented result must match the head of the scoreboard.
   initial begin
      exp_t e;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!GlobalReset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_out: out_valid=1 value=%0d, required no result (cycle %0d)", bus.value, cyc);
               bus.out_ready = 1'b1;
               @(negedge clk);
               bus.out_ready = 1'b0;
            end else begin
               e = exp_q.pop_front();
               check("value", bus.value, e.val);
               check("latency_edge", longint'(cyc), longint'(e.due));
               for (int h = 0; h < e.hold; h++) begin
                  @(negedge clk);
                  check("hold_valid", longint'(bus.out_valid), 1);
                  check("hold_value", bus.value, e.val);
               end
               bus.out_ready = 1'b1;
               @(negedge clk);
               bus.out_ready = 1'b0;
               check("valid_drop", longint'(bus.out_valid), 0);
               done_cnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!GlobalReset && bus.in_ready && (bus.out_valid || !bus.busy)) begin
         mismatched++;
         $display("FAIL ready_outside_run: in_ready=1 with out_valid=%0d busy=%0d, required in_ready=0", bus.out_valid, bus.busy);
      end
   end

   // mode: 0 random, 1 px=1/wt=2, 2 px=1023/wt=min, 3 px=3/wt=-4, 4 random small weights
   // bub:  0 none, 1 alternate cycles, 2 random
   task automatic run_job(input int len, input int mode, input int bub, input bit poke,
                          input int hold, input bit abort, input bit use_fixed, input longint fixed);
      logic [P-1:0] pl;
      logic [W-1:0] wl;
      int           i, guard, tmp, d0, t;
      bit           idle, tog;
      int unsigned  last_edge;
      exp_t         e;
      longint       res;

      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = LW'(len);
      model_clear();
      if (len == 0) begin
         e.val = use_fixed ? fixed : 0;
         e.due = cyc + 1;
         e.hold = hold;
         exp_q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
      last_edge = 0;
      if (len != 0) begin
         i = 0; guard = 0; tog = 1'b0;
         while (i < len) begin
            idle = (bub == 1) ? tog : (bub == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tog = ~tog;
            for (int k = 0; k < L; k++) begin
               case (mode)
                  1: begin pl = P'(1); wl = W'(2); end
                  2: begin pl = '1; wl = {1'b1, {(W-1){1'b0}}}; end
                  3: begin pl = P'(3); tmp = -4; wl = W'(tmp); end
                  4: begin pl = P'($urandom); tmp = int'($urandom_range(0, 4000)) - 2000; wl = W'(tmp); end
                  default: begin pl = P'($urandom); wl = W'($urandom); end
               endcase
               bus.pixels[k*P +: P]  = pl;
               bus.weights[k*W +: W] = wl;
            end
            bus.in_valid = ~idle;
            if (poke && i == 1) begin
               bus.start = 1'b1;
               bus.len   = LW'($urandom_range(1, 5));
            end else begin
               bus.start = 1'b0;
            end
            if (!idle && bus.in_ready) begin
               model_beat(bus.pixels, bus.weights);
               i++;
               if (i == len) last_edge = cyc + 1;
            end
            guard++;
            if (guard > 4 * len + 50) begin
               compared++;
               mismatched++;
               $display("FAIL beat_timeout: accepted %0d beats, required %0d", i, len);
               bus.in_valid = 1'b0;
               bus.start = 1'b0;
               return;
            end
            @(negedge clk);
         end
         bus.in_valid = 1'b0;
         bus.start = 1'b0;
         if (abort) begin
            repeat (2) @(negedge clk);
            GlobalReset = 1'b1;
            @(negedge clk);
            check_reset_state();
            GlobalReset = 1'b0;
            repeat (2 * D) @(negedge clk);
            return;
         end
         e.val = use_fixed ? fixed : model_result();
         e.due = last_edge + D + 2;
         e.hold = hold;
         exp_q.push_back(e);
      end
      res = e.val;
      t = 0;
      while (done_cnt == d0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == d0) begin
         compared++;
         mismatched++;
         $display("FAIL result_timeout: no result after %0d cycles, required one", t);
         return;
      end
      repeat (2) @(negedge clk);
      check("idle_hold_value", bus.value, res);
   endtask

   initial begin
      GlobalReset   = 1'b1;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.pixels    = '0;
      bus.weights   = '0;
      repeat (3) @(negedge clk);
      check_reset_state();
      GlobalReset = 1'b0;
      @(negedge clk);

      run_job(3, 1, 0, 1'b0, 0, 1'b0, 1'b1, 12);
      run_job(3, 1, 1, 1'b0, 0, 1'b0, 1'b1, 12);
      run_job(200, 2, 0, 1'b0, 1, 1'b0, 1'b1, -33554432);
      run_job(0, 0, 0, 1'b0, 5, 1'b0, 1'b1, 0);
      run_job(5, 0, 2, 1'b0, 0, 1'b1, 1'b0, 0);
      run_job(1, 3, 0, 1'b0, 0, 1'b0, 1'b1, -24);
      run_job(4, 4, 2, 1'b1, 2, 1'b0, 1'b0, 0);
      for (int n = 0; n < 10; n++) begin
         run_job(int'($urandom_range(1, 12)), (n % 2 == 0) ? 4 : 0, 2, 1'b0,
                 int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);
      end

      repeat (20) @(negedge clk);
      check("scoreboard_empty", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
